// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and parity-mode constants
package uart_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_EVEN  = 2'b01;
    localparam logic [1:0] PAR_ODD   = 2'b10;
    // Mode 11 is treated like PAR_NONE.
    function automatic logic par_on(input logic [1:0] m);
        return (m == PAR_EVEN) || (m == PAR_ODD);
    endfunction
endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer; ports clk, rst (async high), d_i async in, q_o synced out
module uart_sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) ff_q <= {2{RST_VAL}};
        else     ff_q <= {ff_q[0], d_i};
    assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable parity/stop bits and break detect;
// ports: clk, rst, rx line, rx_en, tick_os strobe, parity_mode, stop2 in; rx_data, rx_start,
// rx_busy, rx_done, parity_err, frame_err, break_det out
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OSR    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              rx_en,
    input  logic              tick_os,
    input  logic [1:0]        parity_mode,
    input  logic              stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_start,
    output logic              rx_busy,
    output logic              rx_done,
    output logic              parity_err,
    output logic              frame_err,
    output logic              break_det
);
    localparam int            TW    = $clog2(OSR);
    localparam logic [TW-1:0] T_S0  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OSR / 2);
    localparam logic [TW-1:0] T_S2  = TW'(OSR / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OSR - 1);
    localparam logic [3:0]    B_END = 4'(DATA_W - 1);

    logic              rx_s;
    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [3:0]        bit_q, bit_d;
    logic [1:0]        vote_q, vote_d, pmode_q, pmode_d;
    logic [DATA_W-1:0] shreg_q, shreg_d, data_q, data_d;
    logic              stop2_q, stop2_d, stp_q, stp_d, par_q, par_d, zero_q, zero_d;
    logic              perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d, hold_q, hold_d;
    logic              start_q, start_d, busy_q, busy_d, done_q, done_d;
    logic              perr_o_q, perr_o_d, ferr_o_q, ferr_o_d, brk_o_q, brk_o_d;
    logic              vbit, samp, ferr_n, brk_n;

    uart_sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d_i(rx), .q_o(rx_s));

    // vote_q counts ones among the three mid-bit samples; bit 1 set means at least two.
    assign vbit   = vote_q[1];
    assign samp   = (tick_q == T_S0) || (tick_q == T_S1) || (tick_q == T_S2);
    assign ferr_n = ferr_q | ~vbit;
    // Break is decided on the first stop bit; later stop bits keep the verdict.
    assign brk_n  = stp_q ? brk_q : (zero_q & ~vbit);

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        vote_d   = vote_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        pmode_d  = pmode_q;
        stop2_d  = stop2_q;
        stp_d    = stp_q;
        par_d    = par_q;
        zero_d   = zero_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        brk_d    = brk_q;
        busy_d   = busy_q;
        perr_o_d = perr_o_q;
        ferr_o_d = ferr_o_q;
        brk_o_d  = brk_o_q;
        // After a break the line must go high before a new start is accepted.
        hold_d   = hold_q & ~rx_s;
        start_d  = 1'b0;
        done_d   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (rx_en && !rx_s && !hold_q) begin
                state_d = ST_START;
                start_d = 1'b1;
                busy_d  = 1'b1;
                tick_d  = '0;
                vote_d  = '0;
                bit_d   = '0;
                stp_d   = 1'b0;
                par_d   = 1'b0;
                zero_d  = 1'b1;
                perr_d  = 1'b0;
                ferr_d  = 1'b0;
                brk_d   = 1'b0;
                pmode_d = parity_mode;
                stop2_d = stop2;
            end
        end else if (tick_os) begin
            tick_d = tick_q + 1'b1;
            if (samp) vote_d = vote_q + {1'b0, rx_s};
            if (state_q == ST_START && tick_q == T_S0 && rx_s) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else if (tick_q == T_END) begin
                vote_d = '0;
                case (state_q)
                    ST_START: state_d = ST_DATA;
                    ST_DATA: begin
                        shreg_d = {vbit, shreg_q[DATA_W-1:1]};
                        par_d   = par_q ^ vbit;
                        zero_d  = zero_q & ~vbit;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == B_END) state_d = par_on(pmode_q) ? ST_PARITY : ST_STOP;
                    end
                    ST_PARITY: begin
                        perr_d  = par_q ^ vbit ^ (pmode_q == PAR_ODD);
                        zero_d  = zero_q & ~vbit;
                        state_d = ST_STOP;
                    end
                    ST_STOP: begin
                        ferr_d = ferr_n;
                        brk_d  = brk_n;
                        stp_d  = 1'b1;
                        if (stp_q == stop2_q) begin
                            state_d  = ST_IDLE;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            data_d   = shreg_q;
                            perr_o_d = perr_q;
                            ferr_o_d = ferr_n;
                            brk_o_d  = brk_n;
                            hold_d   = brk_n;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            vote_q   <= '0;
            shreg_q  <= '0;
            data_q   <= '0;
            pmode_q  <= PAR_NONE;
            stop2_q  <= 1'b0;
            stp_q    <= 1'b0;
            par_q    <= 1'b0;
            zero_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
            hold_q   <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            perr_o_q <= 1'b0;
            ferr_o_q <= 1'b0;
            brk_o_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            vote_q   <= vote_d;
            shreg_q  <= shreg_d;
            data_q   <= data_d;
            pmode_q  <= pmode_d;
            stop2_q  <= stop2_d;
            stp_q    <= stp_d;
            par_q    <= par_d;
            zero_q   <= zero_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            brk_q    <= brk_d;
            hold_q   <= hold_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            perr_o_q <= perr_o_d;
            ferr_o_q <= ferr_o_d;
            brk_o_q  <= brk_o_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_start   = start_q;
    assign rx_busy    = busy_q;
    assign rx_done    = done_q;
    assign parity_err = perr_o_q;
    assign frame_err  = ferr_o_q;
    assign break_det  = brk_o_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for two receiver configurations (8b/OSR8 and 7b/OSR16)
module tb_uart_rx_cfg;
    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic       rx_a = 1'b1, en_a = 1'b0, s2_a = 1'b0;
    logic       rx_b = 1'b1, en_b = 1'b0, s2_b = 1'b0;
    logic [1:0] pm_a = 2'b00, pm_b = 2'b00;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       start_a, busy_a, done_a, perr_a, ferr_a, brk_a;
    logic       start_b, busy_b, done_b, perr_b, ferr_b, brk_b;
    exp_t       q_a[$], q_b[$];
    exp_t       e_a, e_b;
    int         checks = 0, failures = 0;
    int         starts_a = 0, starts_b = 0, exp_starts_a = 0, exp_starts_b = 0;

    uart_rx_cfg #(.DATA_W(8), .OSR(8)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rx_en(en_a), .tick_os(tick), .parity_mode(pm_a),
        .stop2(s2_a), .rx_data(data_a), .rx_start(start_a), .rx_busy(busy_a), .rx_done(done_a),
        .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a));

    uart_rx_cfg #(.DATA_W(7), .OSR(16)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rx_en(en_b), .tick_os(tick), .parity_mode(pm_b),
        .stop2(s2_b), .rx_data(data_b), .rx_start(start_b), .rx_busy(busy_b), .rx_done(done_b),
        .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b));

    always #5 clk = ~clk;

    initial forever begin
        repeat (2) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    end

    task automatic cmp(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Expected frame outcome straight from the frame's bit contents.
    function automatic exp_t model(input int dw, input logic [8:0] d, input logic [1:0] pm,
                                   input logic s2, input logic pbit, input logic [1:0] stops);
        exp_t e;
        int   ones = 0;
        int   pen  = (pm == 2'b01 || pm == 2'b10) ? 1 : 0;
        int   m    = int'(d) % (1 << dw);
        for (int i = 0; i < dw; i++) ones += (m >> i) & 1;
        e.data = 9'(m);
        e.perr = pen == 1 && ((ones + int'(pbit)) % 2) != ((pm == 2'b10) ? 1 : 0);
        e.ferr = !stops[0] || (s2 && !stops[1]);
        e.brk  = m == 0 && !(pen == 1 && pbit) && !stops[0];
        return e;
    endfunction

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int u, input logic v);
        if (u == 0) rx_a = v;
        else rx_b = v;
    endtask

    task automatic cfg(input int u, input logic en, input logic [1:0] pm, input logic s2);
        if (u == 0) begin en_a = en; pm_a = pm; s2_a = s2; end
        else begin en_b = en; pm_b = pm; s2_b = s2; end
    endtask

    // One bit time; a glitch flips the line for one tick period mid-bit.
    task automatic send_bit(input int u, input logic b, input int osr, input logic g);
        set_rx(u, b);
        if (g) begin
            wait_ticks(osr / 2);
            set_rx(u, ~b);
            wait_ticks(1);
            set_rx(u, b);
            wait_ticks(osr / 2 - 1);
        end else wait_ticks(osr);
    endtask

    task automatic send_frame(input int u, input logic [8:0] d, input logic [1:0] pm, input logic s2,
                              input logic pbit, input logic [1:0] stops, input logic g, input logic scramble);
        int dw  = (u == 0) ? 8 : 7;
        int osr = (u == 0) ? 8 : 16;
        cfg(u, 1'b1, pm, s2);
        if (u == 0) begin q_a.push_back(model(dw, d, pm, s2, pbit, stops)); exp_starts_a++; end
        else begin q_b.push_back(model(dw, d, pm, s2, pbit, stops)); exp_starts_b++; end
        send_bit(u, 1'b0, osr, 1'b0);
        cmp(u == 0 ? "a_busy_in_frame" : "b_busy_in_frame", u == 0 ? int'(busy_a) : int'(busy_b), 1);
        if (scramble) cfg(u, 1'($urandom), 2'($urandom), 1'($urandom));
        for (int i = 0; i < dw; i++) send_bit(u, d[i], osr, g);
        if (pm == 2'b01 || pm == 2'b10) send_bit(u, pbit, osr, 1'b0);
        send_bit(u, stops[0], osr, 1'b0);
        if (s2) send_bit(u, stops[1], osr, 1'b0);
        set_rx(u, 1'b1);
        wait_ticks(2 * osr);
    endtask

    always @(negedge clk) begin
        if (start_a) starts_a++;
        if (done_a) begin
            if (q_a.size() == 0) cmp("a_unexpected_done", int'(data_a), -1);
            else begin
                e_a = q_a.pop_front();
                cmp("a_data", int'(data_a), int'(e_a.data));
                cmp("a_parity_err", int'(perr_a), int'(e_a.perr));
                cmp("a_frame_err", int'(ferr_a), int'(e_a.ferr));
                cmp("a_break_det", int'(brk_a), int'(e_a.brk));
            end
        end
    end

    always @(negedge clk) begin
        if (start_b) starts_b++;
        if (done_b) begin
            if (q_b.size() == 0) cmp("b_unexpected_done", int'(data_b), -1);
            else begin
                e_b = q_b.pop_front();
                cmp("b_data", int'(data_b), int'(e_b.data));
                cmp("b_parity_err", int'(perr_b), int'(e_b.perr));
                cmp("b_frame_err", int'(ferr_b), int'(e_b.ferr));
                cmp("b_break_det", int'(brk_b), int'(e_b.brk));
            end
        end
    end

    initial begin
        int         u;
        logic [8:0] d;
        logic [1:0] pm, st;
        logic       s2, pb;
        repeat (3) @(posedge clk);
        #1;
        cmp("a_reset", int'({data_a, start_a, busy_a, done_a, perr_a, ferr_a, brk_a}), 0);
        cmp("b_reset", int'({data_b, start_b, busy_b, done_b, perr_b, ferr_b, brk_b}), 0);
        rst = 1'b0;
        wait_ticks(4);
        send_frame(0, 9'h0A5, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        send_frame(1, 9'h055, 2'b01, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
        send_frame(1, 9'h055, 2'b01, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
        cfg(0, 1'b1, 2'b00, 1'b0);
        exp_starts_a++;
        send_bit(0, 1'b0, 2, 1'b0);
        set_rx(0, 1'b1);
        wait_ticks(16);
        cmp("a_false_start_busy", int'(busy_a), 0);
        cfg(0, 1'b0, 2'b00, 1'b0);
        send_bit(0, 1'b0, 16, 1'b0);
        set_rx(0, 1'b1);
        wait_ticks(16);
        cmp("a_rx_en_off_busy", int'(busy_a), 0);
        cfg(0, 1'b1, 2'b00, 1'b0);
        q_a.push_back(model(8, 9'h000, 2'b00, 1'b0, 1'b0, 2'b00));
        exp_starts_a++;
        send_bit(0, 1'b0, 12 * 8, 1'b0);
        cmp("a_break_no_restart", int'(busy_a), 0);
        set_rx(0, 1'b1);
        wait_ticks(16);
        send_frame(0, 9'h03C, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b0);
        exp_starts_a++;
        send_bit(0, 1'b0, 8, 1'b0);
        send_bit(0, 1'b1, 8, 1'b0);
        send_bit(0, 1'b0, 8, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("a_rst_data", int'(data_a), 0);
        cmp("a_rst_busy", int'(busy_a), 0);
        rst = 1'b0;
        set_rx(0, 1'b1);
        wait_ticks(16);
        send_frame(0, 9'h042, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
        for (int n = 0; n < 24; n++) begin
            u  = int'($urandom_range(0, 1));
            d  = ($urandom_range(0, 5) == 0) ? 9'h000 : 9'($urandom);
            pm = 2'($urandom);
            s2 = 1'($urandom);
            pb = 1'($urandom);
            st = 2'b11;
            if ($urandom_range(0, 3) == 0) st[0] = 1'b0;
            if ($urandom_range(0, 3) == 0) st[1] = 1'b0;
            send_frame(u, d, pm, s2, pb, st, 1'($urandom), 1'b1);
        end
        for (int i = 0; i < 5000 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
        #1;
        cmp("a_pending_frames", q_a.size(), 0);
        cmp("b_pending_frames", q_b.size(), 0);
        cmp("a_start_pulses", starts_a, exp_starts_a);
        cmp("b_start_pulses", starts_b, exp_starts_b);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal 5..9.
REQ-002 Parameter OSR, default 8, tick_os pulses per bit; legal 8 or 16.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port rx  in  1  serial line, asynchronous, idle high.
REQ-006 Port rx_en  in  1  enables detection of a new start bit.
REQ-007 Port tick_os  in  1  one-clk oversample strobe, OSR per bit time.
REQ-008 Port parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 Port stop2  in  1  1 = two stop bits expected.
REQ-010 Port rx_data  out  DATA_W  last received word, LSB first on line.
REQ-011 Port rx_start  out  1  one-clk pulse on start-bit detection.
REQ-012 Port rx_busy  out  1  high from start detection to end of frame.
REQ-013 Port rx_done  out  1  one-clk pulse, frame complete, rx_data valid.
REQ-014 Port parity_err  out  1  status qualified by rx_done.
REQ-015 Port frame_err  out  1  status qualified by rx_done.
REQ-016 Port break_det  out  1  status qualified by rx_done.

Function
REQ-017 rx passes through a 2-FF synchronizer; the second stage is the sampled line.
REQ-018 States: IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE: rx_en=1 and synced rx=0 -> START same cycle; rx_start=1 and rx_busy=1 next cycle; tick counter cleared; parity_mode and stop2 latched. With rx_en=0, no start is detected.
REQ-020 All counters advance only on tick_os; tick counter runs 0..OSR-1 and wraps.
REQ-021 START: at tick count OSR/2-1, synced rx=1 -> IDLE with rx_busy=0 and no rx_done (false start). Otherwise at OSR-1 -> DATA.
REQ-022 Bit value: majority of 3 samples at tick counts OSR/2-1, OSR/2, OSR/2+1; vote accumulator cleared at each bit boundary.
REQ-023 DATA: at OSR-1, shift the voted bit into a DATA_W shift register from the MSB side (LSB received first). After DATA_W bits -> PARITY if the latched mode is even/odd, else STOP.
REQ-024 PARITY: voted bit checked against XOR of data bits (even: XOR of data^parity=0; odd: =1); at OSR-1 -> STOP.
REQ-025 STOP: one or two (latched stop2) stop bits voted; any stop bit voted 0 sets frame error. At OSR-1 of the last stop bit: rx_data<=shift register, status outputs updated, rx_done=1 for one clk, rx_busy=0, -> IDLE.
REQ-026 break_det=1 when all data bits, parity bit (if any) and first stop bit voted 0; frame_err is also 1 in that case.
REQ-027 Status outputs hold until the next rx_done; rx_data holds between frames.
REQ-028 Changes to rx_en, parity_mode or stop2 mid-frame do not affect the frame in progress.
REQ-029 A falling edge on rx in the same cycle as rx_done is not detected; IDLE detects it on the following cycle if rx is still low.
REQ-030 In non-IDLE states rx_start and rx_done are 0 except as specified; tick_os absent -> state frozen.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE; all counters, shift register and rx_data=0; rx_start, rx_busy, rx_done, parity_err, frame_err, break_det=0; synchronizer flops=1.
REQ-032 rst mid-frame aborts the frame without an rx_done pulse; normal reception restarts at the first start bit after release.

Structure
REQ-033 Shared package uart_pkg holds the state encoding and the parity_mode constants (PAR_NONE, PAR_EVEN, PAR_ODD).
REQ-034 One sub-module, uart_sync_2ff (reset value 1), implements REQ-017; all else is in uart_rx_cfg.

Verification
REQ-035 DATA_W=8, OSR=8, no parity, 1 stop, byte 0xA5 -> one rx_done, rx_data=0xA5, all status outputs 0.
REQ-036 DATA_W=7, OSR=16, even parity, 2 stops, 0x55 with parity bit 1 -> rx_data=0x55, parity_err=1; repeated with parity bit 0 -> parity_err=0.
REQ-037 Low pulse of 2 tick_os periods in IDLE -> rx_start pulse, return to IDLE, no rx_done.
REQ-038 Line held low for 12 bit times -> rx_done with rx_data=0, frame_err=1, break_det=1; no new start until rx returns high then falls.
REQ-039 Single-sample glitch inside each data bit of 0x3C -> rx_data=0x3C (majority vote).
REQ-040 rst asserted in DATA of frame 0x81, then 0x42 sent -> no rx_done for 0x81, rx_data=0x42.
